// File: rtl/register_7_loader_pkg.sv
// register_7_loader_pkg: shared states and constants for the 7-bit serial loader
package reg7_loader_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, COMMIT} state_t;
  localparam int REG7_WIDTH = 7;
  localparam int REG7_TIMEOUT = 15;
endpackage

// File: rtl/register_7_loader_if.sv
// register_7_loader_if: serial bit stream in, parallel word and strobes out
interface register_7_loader_if import reg7_loader_pkg::*; #(
  parameter int WIDTH = REG7_WIDTH
);
  logic start, bit_valid, bit_in, bit_ready, write_ctrl, busy, err;
  logic [WIDTH-1:0] data_out;
  modport master (output start, bit_valid, bit_in, input bit_ready, data_out, write_ctrl, busy, err);
  modport slave (input start, bit_valid, bit_in, output bit_ready, data_out, write_ctrl, busy, err);
endinterface

// File: rtl/register_7_loader_timeout_counter.sv
// timeout_counter: saturating idle counter, expired while the count equals TIMEOUT
module timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] count;
  assign expired = count == 8'(TIMEOUT);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !expired) count <= count + 8'd1;
endmodule

// File: rtl/register_7_loader.sv
// register_7_loader: LSB-first serial-to-parallel loader for the 7-bit register stage
// REG7_LOADER_PARITY_EN adds a trailing even-parity bit checked before commit
module register_7_loader import reg7_loader_pkg::*; #(
  parameter int WIDTH = REG7_WIDTH,
  parameter int TIMEOUT = REG7_TIMEOUT
) (
  input logic clk,
  input logic clr_n,
  register_7_loader_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef REG7_LOADER_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = COMMIT;
`endif
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic in_frame, restart, accept, last, expired, abort;
  assign in_frame = state == SHIFT || state == PARITY;
  assign bus.bit_ready = in_frame;
  assign bus.busy = state != IDLE;
  assign restart = state == SHIFT && bus.start;
  assign accept = in_frame && bus.bit_valid && !restart;
  assign last = cnt == CW'(WIDTH - 1);
  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk),
    .clr_n(clr_n),
    .clr(!in_frame || accept || restart),
    .inc(in_frame),
    .expired(expired)
  );
  // start during SHIFT outranks a same-cycle bit; an accept outranks expiry
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    sr_nxt = sr;
    abort = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        sr_nxt = '0;
        state_nxt = bus.start ? SHIFT : IDLE;
      end
      SHIFT:
        if (restart) begin
          cnt_nxt = '0;
          sr_nxt = '0;
        end else if (accept) begin
          sr_nxt[cnt] = bus.bit_in;
          cnt_nxt = last ? '0 : cnt + CW'(1);
          state_nxt = last ? AFTER_DATA : SHIFT;
        end else if (expired) begin
          state_nxt = IDLE;
          abort = 1'b1;
        end
`ifdef REG7_LOADER_PARITY_EN
      PARITY:
        if (accept) begin
          state_nxt = (bus.bit_in == ^sr) ? COMMIT : IDLE;
          abort = bus.bit_in != ^sr;
        end else if (expired) begin
          state_nxt = IDLE;
          abort = 1'b1;
        end
`endif
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      bus.data_out <= '0;
      bus.write_ctrl <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      sr <= sr_nxt;
      bus.write_ctrl <= state_nxt == COMMIT;
      bus.err <= abort;
      if (state_nxt == COMMIT) bus.data_out <= sr_nxt;
    end
endmodule

// File: doc/register_7_loader.md
# register_7_loader

Serial-to-parallel front end that assembles a 7-bit word from a one-bit-per-cycle valid/ready stream and commits it to the downstream 7-bit register stage. It sits directly upstream of the 7-bit register and drives that stage's `in` bus with `data_out` and its `write_ctrl` with `write_ctrl`. An inter-bit timeout aborts stalled frames so a half-loaded word is never committed.

## Interface
- `WIDTH`, 7: word width; must match the downstream register width.
- `TIMEOUT`, 15: maximum idle cycles between accepted bits in a frame before abort; range 1..255.

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  rising-edge clock.
- `clr_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a new frame.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_in`  in  1  serial data, LSB first.
- `bit_ready`  out  1  loader accepts a bit this cycle.
- `data_out`  out  WIDTH  assembled word; drives the downstream register `in`.
- `write_ctrl`  out  1  one-cycle commit strobe to the downstream register.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle pulse on aborted or rejected frame.

## Operation
- States: IDLE, SHIFT, COMMIT (plus PARITY when `REG7_LOADER_PARITY_EN` is defined).
- IDLE:
  - `start`=1 moves to SHIFT.
  - Clears the bit counter, shift register and timeout counter.
- SHIFT:
  - `bit_ready`=1.
  - A bit is accepted when `bit_valid && bit_ready`. It is written into shift position `count`, and `count` increments.
  - After the WIDTH-th accept, moves to COMMIT (or to PARITY when the macro is defined).
- COMMIT:
  - `data_out` loads the shift register and `write_ctrl`=1 for exactly this cycle.
  - Returns to IDLE.
- `data_out` holds its last committed value at all other times; it never shows partial frames.
- Timeout:
  - In SHIFT, each cycle without an accept increments the timeout counter; an accept clears it.
  - When the counter reaches TIMEOUT, the FSM moves to IDLE, `err` pulses for 1 cycle, and there is no write.
- `start` during SHIFT restarts the frame: counters and shift register clear, state stays SHIFT, no `err`.
- `start` during COMMIT or PARITY is ignored.
- Bit accept and timeout expiry in the same cycle: the accept wins and the counter clears.
- `bit_valid` outside SHIFT is ignored; the bit is dropped.

## Timing
- Reset values:
  - state IDLE
  - `data_out`=0
  - `write_ctrl`=0
  - `bit_ready`=0
  - `busy`=0
  - `err`=0
- Reset mid-frame discards the frame immediately; no write is issued.
- `start` sampled high at edge N: `bit_ready`=1 from cycle N+1.
- Back-to-back bits with no parity: accepts in cycles N+1..N+7; `write_ctrl` and the new `data_out` are visible in cycle N+8; `busy`=0 in cycle N+9.
- All outputs are registered except `bit_ready` and `busy`, which decode the state register directly.
- The downstream register captures `data_out` on the edge ending the `write_ctrl` cycle.

## Configuration
- `REG7_LOADER_PARITY_EN` defined:
  - After the WIDTH-th data bit, PARITY accepts one more bit (`bit_ready`=1) as the even-parity bit over the data.
  - Match leads to COMMIT.
  - Mismatch leads to IDLE with a 1-cycle `err` pulse and no write.
  - The timeout applies in PARITY too.
  - Latency grows by one accept.
- Not defined: there is no PARITY state; the frame is exactly WIDTH bits.

## Structure
- Package `reg7_loader_pkg`:
  - state enum (IDLE, SHIFT, PARITY, COMMIT)
  - `REG7_WIDTH`=7
  - default `TIMEOUT` constant
- Sub-module `timeout_counter`: saturating counter with clear and increment inputs and an `expired` output when the count equals TIMEOUT. One instance.

## Test plan
- Reset then idle: `data_out`=0, `write_ctrl`=0, `busy`=0 throughout; `bit_valid` pulses in IDLE produce no write.
- `start`, then bits 1,0,1,1,0,0,1 LSB-first back-to-back -> `write_ctrl` high exactly one cycle at N+8 with `data_out`=7'h4D; `data_out` held afterwards.
- `start`, 3 bits, then `bit_valid`=0 for 15 cycles -> `err` one-cycle pulse, no `write_ctrl`, `data_out` unchanged, FSM in IDLE.
- `start`, 4 bits, `start` again, then 7 bits of 7'h2A -> single commit with `data_out`=7'h2A and no `err`.
- `clr_n` low after the 5th bit -> all outputs 0 asynchronously; after release, a full frame of 7'h7F commits correctly.
- With `REG7_LOADER_PARITY_EN`: 7'h4D plus parity 0 commits; 7'h4D plus parity 1 -> `err` pulse, no write.
